// File: rtl/i2c_write_scheduler_pkg.sv
// Shared definitions for the I2C write scheduler.
//   - state_t      : scheduler FSM states
//   - frame widths : device address / register / value / request / frame
//   - BOOT_TABLE   : power-up register writes, issued in index order
//   - boot_req     : guarded boot table lookup
//   - pack_frame   : builds the 24-bit frame {dev_addr, reg, value}
package i2c_write_scheduler_pkg;

  localparam int ADDR_W   = 8;
  localparam int REG_W    = 7;
  localparam int VAL_W    = 9;
  localparam int REQ_W    = REG_W + VAL_W;
  localparam int FRAME_W  = ADDR_W + REQ_W;
  localparam int BOOT_LEN = 10;
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOOT_ISSUE,
    S_BOOT_WAIT,
    S_GAP,
    S_RUN_IDLE,
    S_RUN_ISSUE,
    S_RUN_WAIT,
    S_ERROR
  } state_t;

  // Each entry is {register[6:0], value[8:0]}.
  localparam logic [REQ_W-1:0] BOOT_TABLE [BOOT_LEN] = '{
    {7'd9, 9'h001},
    {7'd8, 9'h019},
    {7'd7, 9'h042},
    {7'd6, 9'h000},
    {7'd5, 9'h000},
    {7'd4, 9'h015},
    {7'd3, 9'h079},
    {7'd2, 9'h079},
    {7'd1, 9'h097},
    {7'd0, 9'h097}
  };

  function automatic logic [REQ_W-1:0] boot_req(input logic [IDX_W-1:0] idx);
    boot_req = '0;
    if (idx < IDX_W'(BOOT_LEN)) boot_req = BOOT_TABLE[idx];
  endfunction

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [ADDR_W-1:0] dev_addr,
                                                    input logic [REQ_W-1:0]  req);
    pack_frame = {dev_addr, req};
  endfunction

endpackage

// File: rtl/i2c_write_scheduler_if.sv
// Bus bundle between the write scheduler and its environment.
//   slave  : the scheduler side (takes start / requests / frame status,
//            drives frame start and data, ready and status flags)
//   master : the controller / frame-engine side
interface i2c_write_scheduler_if;
  import i2c_write_scheduler_pkg::*;

  logic               i_start;
  logic               i_req_valid;
  logic [REQ_W-1:0]   i_req_data;
  logic               o_req_ready;
  logic               o_frm_start;
  logic [FRAME_W-1:0] o_frm_data;
  logic               i_frm_done;
  logic               i_frm_ack_ok;
  logic               o_boot_done;
  logic               o_busy;
  logic               o_err;

  modport slave (
    input  i_start, i_req_valid, i_req_data, i_frm_done, i_frm_ack_ok,
    output o_req_ready, o_frm_start, o_frm_data, o_boot_done, o_busy, o_err
  );

  modport master (
    output i_start, i_req_valid, i_req_data, i_frm_done, i_frm_ack_ok,
    input  o_req_ready, o_frm_start, o_frm_data, o_boot_done, o_busy, o_err
  );

endinterface

// File: rtl/i2c_write_scheduler_fifo.sv
// sched_fifo: synchronous FIFO holding runtime write requests.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push       : write push_data when not full (dropped when full)
//   pop        : discard head entry when not empty
//   head       : current head entry (valid while !empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two, at least 2. Pointers carry one extra
// wrap bit so full and empty are distinguishable.
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2c_write_scheduler.sv
// i2c_write_scheduler: sequences I2C register writes to a frame engine.
// After i_start it plays the fixed boot table, then dispatches queued
// runtime requests. NACKed frames are re-issued up to MAX_RETRY times;
// beyond that the scheduler parks in S_ERROR with o_err set.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : start, request handshake, frame start/data/done/ack,
//                    boot_done / busy / err status
module i2c_write_scheduler
  import i2c_write_scheduler_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR   = 8'h34,
  parameter int                MAX_RETRY  = 3,
  parameter int                GAP_CYCLES = 4,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  i2c_write_scheduler_if.slave  bus
);

  localparam int                RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam int                GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               boot_done_q, boot_done_d;
  logic               err_q, err_d;
  logic [FRAME_W-1:0] frm_data_q, frm_data_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [REQ_W-1:0]   fifo_head;
  logic               boot_pending;
  logic               start_ok;

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (bus.i_req_valid),
    .push_data (bus.i_req_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign boot_pending = (idx_q < IDX_W'(BOOT_LEN));
  // Start is only honoured in the non-busy states.
  assign start_ok     = bus.i_start &&
                        (state_q == S_IDLE || state_q == S_RUN_IDLE || state_q == S_ERROR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      gap_q       <= '0;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
      frm_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      boot_done_q <= boot_done_d;
      err_q       <= err_d;
      frm_data_q  <= frm_data_d;
    end
  end

  // The frame word is loaded on the transition into an issue state so it
  // is already valid in the o_frm_start cycle and stays put until done.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    boot_done_d = boot_done_q;
    err_d       = err_q;
    frm_data_d  = frm_data_q;
    fifo_pop    = 1'b0;

    if (start_ok) begin
      state_d     = S_BOOT_ISSUE;
      idx_d       = '0;
      retry_d     = '0;
      boot_done_d = 1'b0;
      err_d       = 1'b0;
      frm_data_d  = pack_frame(DEV_ADDR, boot_req('0));
    end else begin
      case (state_q)
        S_BOOT_ISSUE: state_d = S_BOOT_WAIT;
        S_RUN_ISSUE:  state_d = S_RUN_WAIT;

        S_BOOT_WAIT, S_RUN_WAIT: begin
          if (bus.i_frm_done) begin
            gap_d = '0;
            if (bus.i_frm_ack_ok) begin
              retry_d = '0;
              state_d = S_GAP;
              if (state_q == S_BOOT_WAIT) idx_d = idx_q + 1'b1;
              else                        fifo_pop = 1'b1;
            end else if (retry_q < RETRY_LIM) begin
              // Same index / same FIFO head: the gap exit re-issues it.
              retry_d = retry_q + 1'b1;
              state_d = S_GAP;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERROR;
            end
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (boot_pending) begin
              state_d    = S_BOOT_ISSUE;
              frm_data_d = pack_frame(DEV_ADDR, boot_req(idx_q));
            end else begin
              boot_done_d = 1'b1;
              if (!fifo_empty) begin
                state_d    = S_RUN_ISSUE;
                frm_data_d = pack_frame(DEV_ADDR, fifo_head);
              end else begin
                state_d = S_RUN_IDLE;
              end
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end

        S_RUN_IDLE: begin
          if (!fifo_empty) begin
            state_d    = S_RUN_ISSUE;
            frm_data_d = pack_frame(DEV_ADDR, fifo_head);
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.o_frm_start = (state_q == S_BOOT_ISSUE) || (state_q == S_RUN_ISSUE);
  assign bus.o_frm_data  = frm_data_q;
  assign bus.o_req_ready = !fifo_full;
  assign bus.o_boot_done = boot_done_q;
  assign bus.o_err       = err_q;
  assign bus.o_busy      = !(state_q == S_IDLE || state_q == S_RUN_IDLE || state_q == S_ERROR);

endmodule
